// File: rtl/controller_io.sv
// controller_io: host side of the PSX controller serial link.
// Runs one poll per start pulse: ATT low, command bytes out on COMMAND,
// reply shifted in from DATA, ACK checked between bytes. Reply bytes
// land in shadow registers and the button/stick outputs load together
// only when a whole, well-formed reply has been received.
module controller_io #(
    parameter int CLK_DIV     = 100,
    parameter int ATT_SETUP   = 100,
    parameter int ACK_TIMEOUT = 1000,
    parameter int BYTE_GAP    = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       DATA,
    input  logic       ACK,
    output logic       COMMAND,
    output logic       ATT,
    output logic       c_clk,
    output logic       SLCT,
    output logic       STRT,
    output logic       UP,
    output logic       DOWN,
    output logic       RGHT,
    output logic       LEFT,
    output logic       L1,
    output logic       L2,
    output logic       R1,
    output logic       R2,
    output logic       TRI,
    output logic       SQU,
    output logic       XXX,
    output logic       CIR,
    output logic       LJOY,
    output logic       RJOY,
    output logic [7:0] LJOY_X,
    output logic [7:0] LJOY_Y,
    output logic [7:0] RJOY_X,
    output logic [7:0] RJOY_Y
);

    localparam int CW = 16;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_M1 = CW'(ATT_SETUP - 1);
    localparam logic [CW-1:0] TO_M1    = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_M1   = CW'(BYTE_GAP - 1);
    localparam logic [7:0]    ID_ANALOG  = 8'h73;
    localparam logic [7:0]    ID_DIGITAL = 8'h41;
    localparam logic [7:0]    HDR_OK     = 8'h5A;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, ACKWAIT, GAP, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_n;
    logic [3:0]      byte_idx, byte_n;
    logic [7:0]      rx, rx_n, rx_full;
    logic            byte_done;
    logic            analog;
    logic [3:0]      last_idx;
    logic [7:0]      cmd_byte;
    logic [1:0]      data_ff, ack_ff;
    logic            data_s, ack_s;
    logic [7:0]      sh_b3, sh_b4, sh_rx, sh_ry, sh_lx, sh_ly;

    assign data_s   = data_ff[1];
    assign ack_s    = ack_ff[1];
    assign rx_full  = {data_s, rx[7:1]};
    assign last_idx = analog ? 4'd8 : 4'd4;

    // Two-flop synchronizers for the pad-driven inputs; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_ff <= 2'b11;
            ack_ff  <= 2'b11;
        end else begin
            data_ff <= {data_ff[0], DATA};
            ack_ff  <= {ack_ff[0], ACK};
        end
    end

    // Command byte for the byte about to be (or being) shifted out.
    always_comb begin
        cmd_byte = 8'h00;
        case (byte_n)
            4'd0:    cmd_byte = 8'h01;
            4'd1:    cmd_byte = 8'h42;
            default: cmd_byte = 8'h00;
        endcase
    end

    // FSM state and bit/byte counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            rx       <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            rx       <= rx_n;
        end
    end

    // Next-state logic: transaction sequencing, reply checks and aborts.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_n     = bit_idx;
        byte_n    = byte_idx;
        rx_n      = rx;
        byte_done = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = SETUP;
                    byte_n  = '0;
                end
            end
            SETUP: begin
                if (cnt == SETUP_M1) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    bit_n   = '0;
                end
            end
            SHIFT: begin
                // Bit boundary: DATA is taken on the last high cycle.
                if (cnt == BIT_M1) begin
                    cnt_n = '0;
                    rx_n  = rx_full;
                    if (bit_idx == 3'd7) begin
                        byte_done = 1'b1;
                        if (byte_idx == 4'd1 && rx_full != ID_ANALOG && rx_full != ID_DIGITAL)
                            state_n = IDLE;
                        else if (byte_idx == 4'd2 && rx_full != HDR_OK)
                            state_n = IDLE;
                        else if (byte_idx == last_idx)
                            state_n = DONE;
                        else
                            state_n = ACKWAIT;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            ACKWAIT: begin
                if (!ack_s) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else if (cnt == TO_M1) begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (cnt == GAP_M1) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    bit_n   = '0;
                    byte_n  = byte_idx + 4'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered link outputs, decoded from the next state so they are glitch-free.
    // COMMAND holds its last bit between bytes so it only moves on c_clk falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ATT     <= 1'b1;
            c_clk   <= 1'b1;
            COMMAND <= 1'b1;
        end else begin
            ATT   <= (state_n == IDLE);
            c_clk <= !(state_n == SHIFT && cnt_n <= HALF_M1);
            if (state_n == SHIFT)
                COMMAND <= cmd_byte[bit_n];
            else if (state_n inside {ACKWAIT, GAP, DONE})
                COMMAND <= COMMAND;
            else
                COMMAND <= 1'b1;
        end
    end

    // Shadow capture of each reply byte as it completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            analog <= 1'b0;
            sh_b3  <= 8'hFF;
            sh_b4  <= 8'hFF;
            sh_rx  <= 8'h80;
            sh_ry  <= 8'h80;
            sh_lx  <= 8'h80;
            sh_ly  <= 8'h80;
        end else if (byte_done) begin
            case (byte_idx)
                4'd1:    analog <= (rx_full == ID_ANALOG);
                4'd3:    sh_b3  <= rx_full;
                4'd4:    sh_b4  <= rx_full;
                4'd5:    sh_rx  <= rx_full;
                4'd6:    sh_ry  <= rx_full;
                4'd7:    sh_lx  <= rx_full;
                4'd8:    sh_ly  <= rx_full;
                default: ;
            endcase
        end
    end

    // Atomic output update at the end of a good poll; wire bits are active-low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {LEFT, DOWN, RGHT, UP, STRT, RJOY, LJOY, SLCT} <= 8'h00;
            {SQU, XXX, CIR, TRI, R1, L1, R2, L2}           <= 8'h00;
            RJOY_X <= 8'h80;
            RJOY_Y <= 8'h80;
            LJOY_X <= 8'h80;
            LJOY_Y <= 8'h80;
        end else if (state == DONE) begin
            {LEFT, DOWN, RGHT, UP, STRT, RJOY, LJOY, SLCT} <= ~sh_b3;
            {SQU, XXX, CIR, TRI, R1, L1, R2, L2}           <= ~sh_b4;
            RJOY_X <= analog ? sh_rx : 8'h80;
            RJOY_Y <= analog ? sh_ry : 8'h80;
            LJOY_X <= analog ? sh_lx : 8'h80;
            LJOY_Y <= analog ? sh_ly : 8'h80;
        end
    end

endmodule

// File: tb/tb_controller_io.sv
// tb_controller_io: table vectors, hand sequences and random polls against
// a byte-level pad model and a rule-based reference of the poll outcome.
module tb_controller_io;

    localparam int CLK_DIV     = 4;
    localparam int ATT_SETUP   = 10;
    localparam int ACK_TIMEOUT = 40;
    localparam int BYTE_GAP    = 6;

    logic clk = 1'b0;
    logic rst, start, DATA, ACK;
    logic COMMAND, ATT, c_clk;
    logic SLCT, STRT, UP, DOWN, RGHT, LEFT, L1, L2, R1, R2, TRI, SQU, XXX, CIR, LJOY, RJOY;
    logic [7:0] LJOY_X, LJOY_Y, RJOY_X, RJOY_Y;

    always #5 clk = ~clk;

    controller_io #(.CLK_DIV(CLK_DIV), .ATT_SETUP(ATT_SETUP),
                    .ACK_TIMEOUT(ACK_TIMEOUT), .BYTE_GAP(BYTE_GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .DATA(DATA), .ACK(ACK),
        .COMMAND(COMMAND), .ATT(ATT), .c_clk(c_clk),
        .SLCT(SLCT), .STRT(STRT), .UP(UP), .DOWN(DOWN), .RGHT(RGHT), .LEFT(LEFT),
        .L1(L1), .L2(L2), .R1(R1), .R2(R2), .TRI(TRI), .SQU(SQU), .XXX(XXX), .CIR(CIR),
        .LJOY(LJOY), .RJOY(RJOY),
        .LJOY_X(LJOY_X), .LJOY_Y(LJOY_Y), .RJOY_X(RJOY_X), .RJOY_Y(RJOY_Y));

    // btn[7:0] follows reply byte 3 bit order, btn[15:8] byte 4.
    typedef struct packed {
        logic [15:0] btn;
        logic [7:0]  rx, ry, lx, ly;
    } outs_t;

    // r[0] is reply byte 0; 72-bit literals read right-to-left.
    typedef struct {
        logic [8:0][7:0] r;
        logic [3:0]      drop;
        outs_t           exp;
        int              ncmd;
    } vec_t;

    localparam outs_t RESET_OUTS = 48'h0000_8080_8080;

    function automatic outs_t dut_outs();
        return {SQU, XXX, CIR, TRI, R1, L1, R2, L2,
                LEFT, DOWN, RGHT, UP, STRT, RJOY, LJOY, SLCT,
                RJOY_X, RJOY_Y, LJOY_X, LJOY_Y};
    endfunction

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: outcome of one poll from the reply bytes and the ACK drop point.
    function automatic void model(input logic [8:0][7:0] r, input logic [3:0] drop,
                                  inout outs_t st, output int n);
        int last;
        last = (r[1] == 8'h73) ? 8 : 4;
        n = 0;
        for (int k = 0; k < 9; k++) begin
            n = k + 1;
            if (k == 1 && r[1] != 8'h73 && r[1] != 8'h41) return;
            if (k == 2 && r[2] != 8'h5A) return;
            if (k == last) begin
                st.btn = ~{r[4], r[3]};
                if (last == 8) {st.rx, st.ry, st.lx, st.ly} = {r[5], r[6], r[7], r[8]};
                else           {st.rx, st.ry, st.lx, st.ly} = 32'h80808080;
                return;
            end
            if (drop == 4'(k)) return;
        end
    endfunction

    // Pad model: drives DATA on c_clk falls, records COMMAND on rises, ACKs each byte.
    logic [8:0][7:0] pad_reply;
    logic [3:0]      pad_drop;
    bit              pad_en;
    logic [7:0]      cmd_q[$];
    logic [2:0]      p_bit;
    logic [3:0]      p_byte;
    logic [7:0]      p_sh;
    int              ack_dly, ack_low;
    logic            p_prev_c = 1'b1;

    always @(negedge clk) begin
        if (rst || ATT) begin
            p_bit = '0; p_byte = '0; DATA = 1'b1; ACK = 1'b1; ack_dly = 0; ack_low = 0;
        end else begin
            if (p_prev_c && !c_clk && pad_en)
                DATA = (p_byte <= 4'd8) ? pad_reply[p_byte][p_bit] : 1'b1;
            if (!p_prev_c && c_clk) begin
                p_sh[p_bit] = COMMAND;
                if (p_bit == 3'd7) begin
                    cmd_q.push_back(p_sh);
                    if (pad_en && p_byte != pad_drop) ack_dly = 8;
                    p_byte = p_byte + 4'd1;
                end
                p_bit = p_bit + 3'd1;
            end
            if (ack_low > 0) begin ACK = 1'b0; ack_low--; end
            else ACK = 1'b1;
            if (ack_dly > 0) begin
                ack_dly--;
                if (ack_dly == 0) ack_low = 4;
            end
        end
        p_prev_c = c_clk;
    end

    // Continuous protocol monitors: c_clk phase lengths, COMMAND edges, atomic outputs.
    int    cclk_viol = 0, cmd_viol = 0, atom_viol = 0, att_low_cycles = 0;
    int    run = 0, falls = 0;
    logic  m_prev_att = 1'b1, m_prev_c = 1'b1, m_prev_cmd = 1'b1;
    outs_t m_prev_o;

    always @(negedge clk) begin
        if (rst) begin
            run = 0; falls = 0; m_prev_att = 1'b1; m_prev_c = 1'b1; m_prev_cmd = 1'b1;
            m_prev_o = dut_outs();
        end else begin
            if (!ATT) att_low_cycles++;
            if (dut_outs() != m_prev_o && !(m_prev_att == 1'b0 && ATT == 1'b1)) atom_viol++;
            if (!ATT && !m_prev_att) begin
                if (c_clk != m_prev_c) begin
                    if (c_clk) begin
                        if (run != CLK_DIV) cclk_viol++;
                    end else begin
                        falls++;
                        if (falls % 8 != 1 && run != CLK_DIV) cclk_viol++;
                    end
                    run = 1;
                end else run++;
                if (COMMAND != m_prev_cmd && !(m_prev_c && !c_clk)) cmd_viol++;
            end else begin
                run = 1; falls = 0;
            end
            m_prev_att = ATT; m_prev_c = c_clk; m_prev_cmd = COMMAND; m_prev_o = dut_outs();
        end
    end

    task automatic wait_att_high();
        for (int i = 0; i < 20000 && !ATT; i++) @(negedge clk);
        chk("att_release", {47'b0, ATT}, 48'd1);
    endtask

    task automatic do_poll(output logic att_after);
        cmd_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        att_after = ATT;
        wait_att_high();
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_cmds(input string nm, input int n);
        int bad;
        logic [7:0] e;
        bad = 0;
        for (int k = 0; k < n && k < cmd_q.size(); k++) begin
            e = (k == 0) ? 8'h01 : (k == 1) ? 8'h42 : 8'h00;
            if (cmd_q[k] !== e) bad++;
        end
        chk({nm, "_ncmd"}, 48'(cmd_q.size()), 48'(n));
        chk({nm, "_cmdbytes"}, 48'(bad), 48'd0);
    endtask

    vec_t  tbl[7];
    outs_t model_st;
    logic  att_after;

    initial begin
        rst = 1'b1; start = 1'b0; pad_en = 1'b0; pad_drop = 4'hF; pad_reply = '1;
        tbl[0] = '{r: 72'hFF_FF_FF_FF_BF_FE_5A_41_FF, drop: 4'hF, exp: 48'h4001_8080_8080, ncmd: 5};
        tbl[1] = '{r: 72'h34_12_FF_00_FF_FF_5A_73_FF, drop: 4'hF, exp: 48'h0000_00FF_1234, ncmd: 9};
        tbl[2] = '{r: 72'hFF_FF_FF_FF_FF_FF_00_73_FF, drop: 4'hF, exp: 48'h0000_00FF_1234, ncmd: 3};
        tbl[3] = '{r: 72'hFF_FF_FF_FF_FF_FF_5A_55_FF, drop: 4'hF, exp: 48'h0000_00FF_1234, ncmd: 2};
        tbl[4] = '{r: 72'hFE_01_7F_80_00_00_5A_73_FF, drop: 4'hF, exp: 48'hFFFF_807F_01FE, ncmd: 9};
        tbl[5] = '{r: 72'hFF_FF_FF_FF_12_34_5A_41_FF, drop: 4'd3, exp: 48'hFFFF_807F_01FE, ncmd: 4};
        tbl[6] = '{r: 72'hFF_FF_FF_FF_55_AA_5A_41_FF, drop: 4'hF, exp: 48'hAA55_8080_8080, ncmd: 5};

        repeat (3) @(negedge clk);
        chk("reset_outs", dut_outs(), RESET_OUTS);
        chk("reset_link", {45'b0, ATT, c_clk, COMMAND}, 48'd7);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // No pad: host sends 0x01, times out waiting for ACK, outputs untouched.
        do_poll(att_after);
        chk("nopad_att_low", {47'b0, att_after}, 48'd0);
        chk_cmds("nopad", 1);
        chk("nopad_outs", dut_outs(), RESET_OUTS);
        att_low_cycles = 0;
        repeat (2000) @(negedge clk);
        chk("nopad_quiet", 48'(att_low_cycles), 48'd0);

        pad_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pad_reply = tbl[i].r;
            pad_drop  = tbl[i].drop;
            do_poll(att_after);
            chk($sformatf("vec%0d_outs", i), dut_outs(), tbl[i].exp);
            chk_cmds($sformatf("vec%0d", i), tbl[i].ncmd);
        end

        // Second start during a poll is dropped, not queued.
        pad_reply = 72'hFF_FF_FF_FF_0F_F0_5A_41_FF;
        pad_drop  = 4'hF;
        cmd_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_att_high();
        att_low_cycles = 0;
        repeat (300) @(negedge clk);
        chk("restart_quiet", 48'(att_low_cycles), 48'd0);
        chk("restart_outs", dut_outs(), 48'hF00F_8080_8080);
        chk_cmds("restart", 5);

        // Reset in the middle of byte 3: link idles at once, outputs to reset values.
        pad_reply = 72'h11_22_33_44_00_00_5A_73_FF;
        cmd_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 5000 && cmd_q.size() < 3; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_link", {45'b0, ATT, c_clk, COMMAND}, 48'd7);
        chk("midrst_outs", dut_outs(), RESET_OUTS);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        att_low_cycles = 0;
        repeat (200) @(negedge clk);
        chk("midrst_quiet", 48'(att_low_cycles), 48'd0);
        chk("midrst_hold", dut_outs(), RESET_OUTS);

        // Random polls against the reference.
        model_st = RESET_OUTS;
        for (int i = 0; i < 40; i++) begin
            logic [8:0][7:0] r;
            int n_exp, u;
            for (int k = 0; k < 9; k++) r[k] = 8'($urandom);
            r[0] = 8'hFF;
            u = $urandom_range(0, 9);
            if (u < 4)      r[1] = 8'h73;
            else if (u < 8) r[1] = 8'h41;
            if ($urandom_range(0, 7) != 0) r[2] = 8'h5A;
            pad_reply = r;
            pad_drop  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 8)) : 4'hF;
            model(r, pad_drop, model_st, n_exp);
            do_poll(att_after);
            chk($sformatf("rnd%0d_outs", i), dut_outs(), model_st);
            chk($sformatf("rnd%0d_ncmd", i), 48'(cmd_q.size()), 48'(n_exp));
        end

        chk("cclk_phase", 48'(cclk_viol), 48'd0);
        chk("cmd_on_fall", 48'(cmd_viol), 48'd0);
        chk("atomic_outs", 48'(atom_viol), 48'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
